// File: rtl/poller_pkg.sv
// Shared types and constants for the AXI4-Lite status poller: response codes,
// sweep FSM states and the register-index width helper.
package poller_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        PUB
    } poll_state_t;

    function automatic int idx_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/poll_timer.sv
// Periodic sweep timer plus the one-deep pending-request latch; req_pulse tells
// the sweep FSM that a sweep is wanted (fresh request or one queued while busy).
module poll_timer #(
    parameter int POLL_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic periodic_en,
    input  logic idle,
    output logic req_pulse
);

    localparam int TW = $clog2(POLL_CYCLES);

    logic [TW-1:0] timer;
    logic          pending;
    logic          timer_fire;
    logic          request;

    assign timer_fire = periodic_en && (timer == TW'(POLL_CYCLES - 1));
    assign request    = start || timer_fire;
    assign req_pulse  = request || pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (!periodic_en || timer_fire) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // The FSM launches whenever it sits in IDLE with req_pulse high, so any
    // pending request is consumed there; requests while busy merge into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (idle) begin
            pending <= 1'b0;
        end else if (request) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/axi_status_poller.sv
// AXI4-Lite read master that sweeps REG_COUNT status registers and publishes
// each sweep as one coherent snapshot. Optional change detection: POLLER_CHANGE_DETECT_EN.
module axi_status_poller
    import poller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          REG_COUNT   = 12,
    parameter int          POLL_CYCLES = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    periodic_en,
    output logic                    busy,
    output logic [32*REG_COUNT-1:0] snapshot,
    output logic                    snap_valid,
    output logic [31:0]             sweep_count,
    output logic                    resp_err,
    output logic [5:0]              err_index,
    input  logic                    err_clear,
`ifdef POLLER_CHANGE_DETECT_EN
    output logic [REG_COUNT-1:0]    changed_mask,
    output logic                    changed,
`endif
    output logic [31:0]             M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    output logic [2:0]              M_AXI_ARPROT,
    input  logic                    M_AXI_ARREADY,
    input  logic [31:0]             M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int IDX_W = idx_width(REG_COUNT);

    poll_state_t             state, state_next;
    logic [IDX_W-1:0]        idx;
    logic [32*REG_COUNT-1:0] shadow;
    logic                    req_pulse;
    logic                    r_done;
    logic                    last_reg;
    logic                    new_err;

    poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .periodic_en(periodic_en),
        .idle       (state == IDLE),
        .req_pulse  (req_pulse)
    );

    assign r_done       = (state == R) && M_AXI_RVALID;
    assign last_reg     = (idx == IDX_W'(REG_COUNT - 1));
    assign new_err      = r_done && (M_AXI_RRESP != AXI_RESP_OKAY);
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_ARADDR = M_AXI_ARVALID ? (BASE_ADDR + (32'(idx) << 2)) : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only one read is ever outstanding: ARVALID lives in AR, RREADY in R.
    always_comb begin
        state_next    = state;
        busy          = 1'b1;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req_pulse) state_next = AR;
            end
            AR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_next = R;
            end
            R: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_next = last_reg ? PUB : AR;
            end
            PUB:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            idx <= '0;
        end else if (r_done && !last_reg) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (r_done) begin
            shadow[32*idx +: 32] <= (M_AXI_RRESP == AXI_RESP_OKAY) ? M_AXI_RDATA : 32'h0;
        end
    end

    // snap_valid is registered so its pulse lines up with the new snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot    <= '0;
            snap_valid  <= 1'b0;
            sweep_count <= 32'h0;
        end else begin
            snap_valid <= (state == PUB);
            if (state == PUB) begin
                snapshot    <= shadow;
                sweep_count <= sweep_count + 32'h1;
            end
        end
    end

    // A new error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err  <= 1'b0;
            err_index <= 6'h0;
        end else if (new_err && (!resp_err || err_clear)) begin
            resp_err  <= 1'b1;
            err_index <= 6'(idx);
        end else if (err_clear) begin
            resp_err  <= 1'b0;
            err_index <= 6'h0;
        end
    end

`ifdef POLLER_CHANGE_DETECT_EN
    logic [REG_COUNT-1:0] diff;

    always_comb begin
        diff = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            diff[i] = (shadow[32*i +: 32] != snapshot[32*i +: 32]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            changed_mask <= '0;
            changed      <= 1'b0;
        end else begin
            changed <= (state == PUB) && (|diff);
            if (state == PUB) changed_mask <= diff;
        end
    end
`endif

endmodule
